// File: rtl/sram_1rw_req_adapter.sv
// Request/response adapter for a single-port 1RW SRAM macro: drives macro strobes on accept,
// captures read data one cycle later and returns in-order responses through a small credit-guarded FIFO.
module sram_1rw_req_adapter #(
   parameter int BITS       = 32,
   parameter int ADDR_WIDTH = 11,
   parameter int RSP_DEPTH  = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_we,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [BITS-1:0]       req_wdata,
   input  logic [BITS/8-1:0]     req_be,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic                  rsp_we,
   output logic [BITS-1:0]       rsp_rdata,
   output logic                  sram_ce_in,
   output logic                  sram_we_in,
   output logic [ADDR_WIDTH-1:0] sram_addr_in,
   output logic [BITS-1:0]       sram_wd_in,
   output logic [BITS-1:0]       sram_w_mask_in,
   input  logic [BITS-1:0]       sram_rd_out
);

   localparam int NBE = BITS / 8;
   localparam int PW  = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
   localparam int CW  = $clog2(RSP_DEPTH + 1) + 1;

   logic          fire, pop, push;
   logic          pend_v_q, pend_v_d;
   logic          pend_we_q, pend_we_d;
   logic [PW-1:0] wptr_q, wptr_d;
   logic [PW-1:0] rptr_q, rptr_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [CW-1:0] credit;

   logic            fifo_we_q [RSP_DEPTH];
   logic [BITS-1:0] fifo_rd_q [RSP_DEPTH];

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(RSP_DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   // Slots committed after this cycle: queued + in flight - leaving now.
   assign pop       = rsp_valid && rsp_ready;
   assign credit    = cnt_q + CW'(pend_v_q) - CW'(pop);
   assign req_ready = !rst && (credit < CW'(RSP_DEPTH));
   assign fire      = req_valid && req_ready;
   assign push      = pend_v_q;

   assign sram_ce_in   = fire;
   assign sram_we_in   = fire && req_we;
   assign sram_addr_in = fire ? req_addr : '0;
   assign sram_wd_in   = fire ? req_wdata : '0;

   for (genvar b = 0; b < NBE; b++) begin : g_mask
      assign sram_w_mask_in[b*8 +: 8] = {8{fire && req_we && req_be[b]}};
   end

   assign rsp_valid = !rst && (cnt_q != '0);
   assign rsp_we    = rsp_valid && fifo_we_q[rptr_q];
   assign rsp_rdata = rsp_valid ? fifo_rd_q[rptr_q] : '0;

   always_comb begin
      pend_v_d  = fire;
      pend_we_d = fire && req_we;
      wptr_d    = wptr_q;
      rptr_d    = rptr_q;
      cnt_d     = cnt_q;
      if (push) wptr_d = ptr_inc(wptr_q);
      if (pop)  rptr_d = ptr_inc(rptr_q);
      case ({push, pop})
         2'b10:   cnt_d = cnt_q + 1'b1;
         2'b01:   cnt_d = cnt_q - 1'b1;
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pend_v_q  <= 1'b0;
         pend_we_q <= 1'b0;
         wptr_q    <= '0;
         rptr_q    <= '0;
         cnt_q     <= '0;
      end else begin
         pend_v_q  <= pend_v_d;
         pend_we_q <= pend_we_d;
         wptr_q    <= wptr_d;
         rptr_q    <= rptr_d;
         cnt_q     <= cnt_d;
      end
   end

   // Entry contents need no reset: the outputs are gated by the count.
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_we_q[wptr_q] <= pend_we_q;
         fifo_rd_q[wptr_q] <= pend_we_q ? '0 : sram_rd_out;
      end
   end

endmodule

// File: tb/tb_sram_1rw_req_adapter.sv
// Scoreboard bench for sram_1rw_req_adapter with a behavioural macro model and reference memory.
module tb_sram_1rw_req_adapter;

   localparam int BITS       = 32;
   localparam int ADDR_WIDTH = 11;
   localparam int RSP_DEPTH  = 2;

   logic                  clk = 1'b0;
   logic                  rst;
   logic                  req_valid, req_ready, req_we;
   logic [ADDR_WIDTH-1:0] req_addr;
   logic [BITS-1:0]       req_wdata;
   logic [BITS/8-1:0]     req_be;
   logic                  rsp_valid, rsp_ready, rsp_we;
   logic [BITS-1:0]       rsp_rdata;
   logic                  sram_ce_in, sram_we_in;
   logic [ADDR_WIDTH-1:0] sram_addr_in;
   logic [BITS-1:0]       sram_wd_in, sram_w_mask_in, sram_rd_out;

   sram_1rw_req_adapter #(.BITS(BITS), .ADDR_WIDTH(ADDR_WIDTH), .RSP_DEPTH(RSP_DEPTH)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_we(rsp_we), .rsp_rdata(rsp_rdata),
      .sram_ce_in(sram_ce_in), .sram_we_in(sram_we_in), .sram_addr_in(sram_addr_in),
      .sram_wd_in(sram_wd_in), .sram_w_mask_in(sram_w_mask_in), .sram_rd_out(sram_rd_out)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   int acc_cnt = 0;
   bit exact_lat = 1'b0;

   typedef struct {
      logic            we;
      logic [BITS-1:0] rd;
      int              acc;
      bit              exact;
   } exp_t;
   exp_t exp_q[$];

   // Macro model: masked write, one-cycle read latency, garbage on non-read cycles.
   logic [BITS-1:0] sram_mem [0:(1<<ADDR_WIDTH)-1];
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (sram_ce_in && sram_we_in)
         sram_mem[sram_addr_in] <= (sram_mem[sram_addr_in] & ~sram_w_mask_in) | (sram_wd_in & sram_w_mask_in);
      sram_rd_out <= (sram_ce_in && !sram_we_in) ? sram_mem[sram_addr_in] : $urandom;
   end

   logic [BITS-1:0] ref_mem [0:(1<<ADDR_WIDTH)-1];

   function automatic logic [BITS-1:0] be2mask(input logic [BITS/8-1:0] be);
      logic [BITS-1:0] m;
      for (int b = 0; b < BITS/8; b++) m[b*8 +: 8] = {8{be[b]}};
      return m;
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   logic            mon_fire, hold_v, hold_we;
   logic [BITS-1:0] hold_rd, mon_mask;
   exp_t            mon_e;

   always @(negedge clk) begin
      if (rst) begin
         chk("rst_req_ready", 64'(req_ready), 0);
         chk("rst_rsp_valid", 64'(rsp_valid), 0);
         chk("rst_rsp_we", 64'(rsp_we), 0);
         chk("rst_rsp_rdata", 64'(rsp_rdata), 0);
         chk("rst_sram_ce", 64'(sram_ce_in), 0);
         chk("rst_sram_we", 64'(sram_we_in), 0);
         chk("rst_sram_addr", 64'(sram_addr_in), 0);
         chk("rst_sram_wd", 64'(sram_wd_in), 0);
         chk("rst_sram_mask", 64'(sram_w_mask_in), 0);
         exp_q.delete();
         hold_v = 1'b0;
      end else begin
         mon_fire = req_valid && req_ready;
         mon_mask = (mon_fire && req_we) ? be2mask(req_be) : '0;
         chk("sram_ce", 64'(sram_ce_in), 64'(mon_fire));
         chk("sram_we", 64'(sram_we_in), 64'(mon_fire && req_we));
         chk("sram_addr", 64'(sram_addr_in), mon_fire ? 64'(req_addr) : 64'(0));
         chk("sram_wd", 64'(sram_wd_in), mon_fire ? 64'(req_wdata) : 64'(0));
         chk("sram_mask", 64'(sram_w_mask_in), 64'(mon_mask));
         if (hold_v) begin
            chk("rsp_hold_valid", 64'(rsp_valid), 1);
            chk("rsp_hold_we", 64'(rsp_we), 64'(hold_we));
            chk("rsp_hold_rdata", 64'(rsp_rdata), 64'(hold_rd));
         end
         if (rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL rsp_unexpected: got we=%0d rdata=%0h, expected no response", rsp_we, rsp_rdata);
            end else begin
               mon_e = exp_q.pop_front();
               chk("rsp_we", 64'(rsp_we), 64'(mon_e.we));
               chk("rsp_rdata", 64'(rsp_rdata), 64'(mon_e.rd));
               if (mon_e.exact) chk("rsp_latency", 64'(cyc - mon_e.acc), 2);
               else             chk("rsp_min_latency", 64'((cyc - mon_e.acc) >= 2), 1);
            end
         end
         hold_v  = rsp_valid && !rsp_ready;
         hold_we = rsp_we;
         hold_rd = rsp_rdata;
         if (mon_fire) begin
            acc_cnt++;
            mon_e.acc   = cyc;
            mon_e.exact = exact_lat;
            if (req_we) begin
               ref_mem[req_addr] = (ref_mem[req_addr] & ~mon_mask) | (req_wdata & mon_mask);
               mon_e.we = 1'b1;
               mon_e.rd = '0;
            end else begin
               mon_e.we = 1'b0;
               mon_e.rd = ref_mem[req_addr];
            end
            exp_q.push_back(mon_e);
         end
      end
   end

   task automatic drive(input logic v, input logic we, input logic [ADDR_WIDTH-1:0] a,
                        input logic [BITS-1:0] d, input logic [BITS/8-1:0] be);
      @(posedge clk); #1;
      req_valid = v; req_we = we; req_addr = a; req_wdata = d; req_be = be;
   endtask

   task automatic settle();
      @(negedge clk); #1;
   endtask

   task automatic drain(input string nm);
      for (int i = 0; i < 200; i++) begin
         if (exp_q.size() == 0) break;
         settle();
      end
      repeat (3) settle();
      chk(nm, 64'(exp_q.size()), 0);
   endtask

   initial begin
      int start;
      rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; req_be = '0;
      rsp_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0; rsp_ready = 1'b1; exact_lat = 1'b1;

      // single full write, read back, partial write, read back
      drive(1, 1, 11'h005, 32'hDEADBEEF, 4'hF);
      @(negedge clk);
      chk("single_wr_ready", 64'(req_ready), 1);
      chk("single_wr_mask", 64'(sram_w_mask_in), 64'h0000_0000_FFFF_FFFF);
      drive(0, 0, '0, '0, '0);
      drive(1, 0, 11'h005, '0, 4'hF);
      @(negedge clk);
      chk("read_ce", 64'(sram_ce_in), 1);
      chk("read_mask", 64'(sram_w_mask_in), 0);
      drive(1, 1, 11'h005, 32'h11223344, 4'b0101);
      @(negedge clk);
      chk("partial_mask", 64'(sram_w_mask_in), 64'h0000_0000_00FF_00FF);
      drive(1, 0, 11'h005, '0, '0);
      drive(0, 0, '0, '0, '0);
      drain("directed_drain");

      // streaming: 16 writes then 16 reads, responses must come every cycle
      for (int i = 0; i < 16; i++) begin
         drive(1, 1, 11'(i), $urandom, 4'hF);
         @(negedge clk);
         chk("stream_wr_ready", 64'(req_ready), 1);
      end
      for (int i = 0; i < 16; i++) begin
         drive(1, 0, 11'(i), $urandom, 4'h0);
         @(negedge clk);
         chk("stream_rd_ready", 64'(req_ready), 1);
      end
      drive(0, 0, '0, '0, '0);
      drain("stream_drain");

      // backpressure: only RSP_DEPTH accepted, rsp_ready frees a slot in the same cycle
      exact_lat = 1'b0;
      @(posedge clk); #1;
      rsp_ready = 1'b0; req_valid = 1'b1; req_we = 1'b0; req_addr = 11'($urandom_range(0, 15));
      start = acc_cnt;
      repeat (6) @(posedge clk);
      settle();
      chk("bp_accepted", 64'(acc_cnt - start), 64'(RSP_DEPTH));
      chk("bp_ready_low", 64'(req_ready), 0);
      @(posedge clk); #1 rsp_ready = 1'b1;
      @(negedge clk);
      chk("bp_ready_same_cycle", 64'(req_ready), 1);
      @(posedge clk); #1 rsp_ready = 1'b0;
      settle();
      chk("bp_ready_low2", 64'(req_ready), 0);
      chk("bp_accepted2", 64'(acc_cnt - start), 64'(RSP_DEPTH + 1));
      @(posedge clk); #1 req_valid = 1'b0; rsp_ready = 1'b1;
      drain("bp_drain");

      // reset with one queued and one pending response
      @(posedge clk); #1 rsp_ready = 1'b0;
      drive(1, 0, 11'h003, '0, '0);
      @(negedge clk);
      chk("rst_seq_acc1", 64'(req_ready), 1);
      drive(1, 0, 11'h007, '0, '0);
      @(negedge clk);
      chk("rst_seq_acc2", 64'(req_ready), 1);
      @(posedge clk); #1 req_valid = 1'b0; rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      settle();
      chk("post_rst_rsp_valid", 64'(rsp_valid), 0);
      chk("post_rst_sram_ce", 64'(sram_ce_in), 0);
      chk("post_rst_queue", 64'(exp_q.size()), 0);
      rsp_ready = 1'b1; exact_lat = 1'b1;
      drive(1, 0, 11'h009, '0, '0);
      drive(0, 0, '0, '0, '0);
      drain("post_rst_drain");

      // random traffic with random backpressure
      exact_lat = 1'b0;
      repeat (400) begin
         @(posedge clk); #1;
         rsp_ready = ($urandom_range(0, 3) != 0);
         req_valid = ($urandom_range(0, 2) != 0);
         req_we    = 1'($urandom_range(0, 1));
         req_addr  = 11'($urandom_range(0, 15));
         req_wdata = $urandom;
         req_be    = 4'($urandom_range(0, 15));
      end
      @(posedge clk); #1 req_valid = 1'b0; rsp_ready = 1'b1;
      drain("random_drain");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL timeout: simulation did not complete, %0d checks, %0d errors", checks, errors);
      $fatal(1, "timeout");
   end

endmodule
